motor_ctrl_mc: RTL
==================

Name: motor_ctrl_mc

Overview:
- Multi-channel successor to the single up/down limit-switch motor FSM.
- Drives CHANNELS independent motors, each with its own Moore FSM.
- Adds a travel timeout, a reversal dead-time, a sensor-contradiction fault and a per-channel fault-clear handshake.
- Sits between the command/limit-switch interface and the motor driver enables.

Parameters:
- CHANNELS, 4, number of independent motor channels.
- TIMEOUT_W, 16, width of the travel/timeout counter.
- TIMEOUT_CYC, 1000, maximum cycles in a MOVE state before a timeout fault; must be >=1 and < 2**TIMEOUT_W.
- DEADTIME_CYC, 8, cycles spent in DWELL after any stop; 0 means stop goes straight to IDLE.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- activate  in  CHANNELS  per-channel run request, level-sensitive.
- up_max  in  CHANNELS  upper limit switch reached.
- dn_max  in  CHANNELS  lower limit switch reached.
- dir  in  CHANNELS  direction used when neither limit is active; 1=up, 0=down.
- clear_fault  in  CHANNELS  single-cycle pulse that releases FAULT.
- up_m  out  CHANNELS  motor-up enable.
- dn_m  out  CHANNELS  motor-down enable.
- busy  out  CHANNELS  channel is not in IDLE.
- fault  out  CHANNELS  channel is in FAULT.
- fault_code  out  2*CHANNELS  per channel, bits [2i+1:2i]: 00 none, 01 timeout, 10 both limits active.

Behaviour:
- Reset (rst=0, asynchronous):
  - every channel goes to IDLE;
  - all outputs are 0, counters are 0, fault_code is 00.
- Outputs are Moore and registered: inputs sampled at edge k appear on the outputs after edge k.
- Outputs per state:
  - MOVE_UP: up_m=1.
  - MOVE_DN: dn_m=1.
  - All other states: up_m=dn_m=0.
  - up_m and dn_m are never both 1.
- States: IDLE, MOVE_UP, MOVE_DN, DWELL, FAULT. Transitions are listed in priority order.
- Any state except FAULT:
  - up_max & dn_max -> FAULT, code 10.
- IDLE, only when activate=1:
  - up_max -> MOVE_DN.
  - else dn_max -> MOVE_UP.
  - else dir=1 -> MOVE_UP, dir=0 -> MOVE_DN.
  - activate=0 -> stay in IDLE.
- MOVE_UP:
  - up_max -> DWELL.
  - else activate=0 -> DWELL (abort).
  - else timeout -> FAULT, code 01.
- MOVE_DN: same as MOVE_UP, with dn_max as the terminating limit.
- Timeout counter:
  - cleared on entry to MOVE_*, then increments once per cycle in MOVE_*.
  - Timeout fires when cnt==TIMEOUT_CYC-1 and the terminating limit is not seen.
  - Limit and timeout on the same edge: the limit wins.
- DWELL:
  - counts DEADTIME_CYC cycles, then goes to IDLE.
  - activate is ignored, so an immediate reversal cannot happen.
  - If DEADTIME_CYC=0, a stop goes directly to IDLE.
- FAULT:
  - fault=1 and fault_code is held.
  - clear_fault=1 -> IDLE and fault_code=00.
  - clear_fault is ignored in all other states.
  - While the both-limits condition persists, the channel re-enters FAULT on the next edge after the clear.
- Channels are fully independent; no shared arbitration.
- Unused upper counter bits stay 0.

Optional Feature:
- Macro: MOTOR_CTRL_TRAVEL_LOG_EN.
- Defined:
  - adds output travel_cyc (CHANNELS*TIMEOUT_W).
  - On each limit-terminated MOVE_*->DWELL transition, the channel's slice latches cnt+1 (cycles spent moving).
  - Aborts and faults leave it unchanged; reset clears it to 0.
- Undefined:
  - port absent, no extra registers.

Decomposition:
- Package motor_ctrl_pkg holds:
  - the state enum: IDLE=3'd0, MOVE_UP=3'd1, MOVE_DN=3'd2, DWELL=3'd3, FAULT=3'd4;
  - fault code constants: FC_NONE=2'b00, FC_TIMEOUT=2'b01, FC_BOTH=2'b10.
- Sub-module motor_ctrl_ch is one channel: FSM, timeout counter, dead-time counter and optional log register.
- motor_ctrl_mc instantiates CHANNELS copies in a generate loop and packs the vectors.

Test Plan (bench overrides CHANNELS=2, TIMEOUT_CYC=20, DEADTIME_CYC=4):
- Ch0 activate=1, up_max=1 -> dn_m[0]=1 after next edge; set dn_max=1, up_max=0 -> dn_m[0]=0 next edge, busy[0]=1 for 4 cycles, then IDLE.
- Ch0 activate=1, no limits, dir=1 held for 20 cycles -> up_m[0]=1 for 20 cycles, then fault[0]=1, fault_code=01, up_m=0; clear_fault pulse -> IDLE, fault_code=00.
- Ch1 up_max=dn_max=1 while in IDLE -> fault[1]=1, code 10; ch0 unaffected and still moves on command.
- Ch0 in MOVE_UP, drop activate, then re-assert on the next cycle with dn_max=1 -> DWELL 4 cycles with up_m=dn_m=0, then MOVE_UP.
- Assert rst=0 mid-MOVE_DN, asynchronously between edges -> all outputs 0 immediately; after release, channel is in IDLE.
- MOTOR_CTRL_TRAVEL_LOG_EN defined: limit reached after 7 cycles in MOVE_DN -> travel_cyc[15:0]=7; an aborted move leaves it at 7.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types for the multi-channel limit-switch motor controller: FSM state encoding and fault codes.
// Pure declarations; no latency or backpressure of its own.
package motor_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE_UP = 3'd1,
        MOVE_DN = 3'd2,
        DWELL   = 3'd3,
        FAULT   = 3'd4
    } mc_state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_BOTH    = 2'b10;

    // Dead-time counter width; at least one bit even when the dwell is disabled.
    function automatic int dw_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/motor_ctrl_ch.sv
// One motor channel: Moore FSM with travel timeout, reversal dead-time and optional travel log (MOTOR_CTRL_TRAVEL_LOG_EN).
// Latency: inputs sampled on an edge are reflected on the registered outputs right after that edge.
// Backpressure: none; level-sensitive run request, clear_fault is only honoured while in FAULT.
module motor_ctrl_ch
    import motor_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W    = 16,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int DEADTIME_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 activate,
    input  logic                 up_max,
    input  logic                 dn_max,
    input  logic                 dir,
    input  logic                 clear_fault,
    output logic                 up_m,
    output logic                 dn_m,
    output logic                 busy,
    output logic                 fault,
    output logic [1:0]           fault_code
`ifdef MOTOR_CTRL_TRAVEL_LOG_EN
    ,
    output logic [TIMEOUT_W-1:0] travel_cyc
`endif
);

    localparam int DW_W = dw_width(DEADTIME_CYC);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [DW_W-1:0]      DW_LAST  = DW_W'((DEADTIME_CYC > 0) ? DEADTIME_CYC - 1 : 0);

    mc_state_e            state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [DW_W-1:0]      dw_q, dw_d;
    logic [1:0]           fc_q, fc_d;
    logic                 lim;
    logic                 stop;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        dw_d    = '0;
        fc_d    = fc_q;
        lim     = 1'b0;
        stop    = 1'b0;
        if (state_q != FAULT && up_max && dn_max) begin
            state_d = FAULT;
            fc_d    = FC_BOTH;
        end else begin
            case (state_q)
                IDLE: begin
                    if (activate) begin
                        if (up_max)      state_d = MOVE_DN;
                        else if (dn_max) state_d = MOVE_UP;
                        else if (dir)    state_d = MOVE_UP;
                        else             state_d = MOVE_DN;
                    end
                end
                MOVE_UP, MOVE_DN: begin
                    lim = (state_q == MOVE_UP) ? up_max : dn_max;
                    // Limit beats abort, abort beats timeout.
                    if (lim || !activate) begin
                        stop = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = FAULT;
                        fc_d    = FC_TIMEOUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DWELL: begin
                    if (dw_q == DW_LAST) state_d = IDLE;
                    else                 dw_d    = dw_q + 1'b1;
                end
                FAULT: begin
                    if (clear_fault) begin
                        state_d = IDLE;
                        fc_d    = FC_NONE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (stop) begin
                if (DEADTIME_CYC == 0) state_d = IDLE;
                else                   state_d = DWELL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dw_q    <= '0;
            fc_q    <= FC_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dw_q    <= dw_d;
            fc_q    <= fc_d;
        end
    end

    assign up_m       = (state_q == MOVE_UP);
    assign dn_m       = (state_q == MOVE_DN);
    assign busy       = (state_q != IDLE);
    assign fault      = (state_q == FAULT);
    assign fault_code = fc_q;

`ifdef MOTOR_CTRL_TRAVEL_LOG_EN
    logic [TIMEOUT_W-1:0] trav_q, trav_d;
    logic                 lim_stop;

    // Only a move ended by its own limit is logged; the both-limits fault takes priority.
    assign lim_stop = (state_q == MOVE_UP && up_max && !dn_max) ||
                      (state_q == MOVE_DN && dn_max && !up_max);

    always_comb begin
        trav_d = trav_q;
        if (lim_stop) trav_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) trav_q <= '0;
        else      trav_q <= trav_d;
    end

    assign travel_cyc = trav_q;
`endif

endmodule

// File: rtl/motor_ctrl_mc.sv
// CHANNELS independent limit-switch motor controllers packed onto flat vectors (MOTOR_CTRL_TRAVEL_LOG_EN adds travel_cyc).
// Latency: one edge from sampled inputs to registered outputs, identical for every channel.
// Backpressure: none; channels share no arbitration.
module motor_ctrl_mc
    import motor_ctrl_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int TIMEOUT_W    = 16,
    parameter int TIMEOUT_CYC  = 1000,
    parameter int DEADTIME_CYC = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           activate,
    input  logic [CHANNELS-1:0]           up_max,
    input  logic [CHANNELS-1:0]           dn_max,
    input  logic [CHANNELS-1:0]           dir,
    input  logic [CHANNELS-1:0]           clear_fault,
    output logic [CHANNELS-1:0]           up_m,
    output logic [CHANNELS-1:0]           dn_m,
    output logic [CHANNELS-1:0]           busy,
    output logic [CHANNELS-1:0]           fault,
    output logic [2*CHANNELS-1:0]         fault_code
`ifdef MOTOR_CTRL_TRAVEL_LOG_EN
    ,
    output logic [CHANNELS*TIMEOUT_W-1:0] travel_cyc
`endif
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        motor_ctrl_ch #(
            .TIMEOUT_W   (TIMEOUT_W),
            .TIMEOUT_CYC (TIMEOUT_CYC),
            .DEADTIME_CYC(DEADTIME_CYC)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .activate   (activate[i]),
            .up_max     (up_max[i]),
            .dn_max     (dn_max[i]),
            .dir        (dir[i]),
            .clear_fault(clear_fault[i]),
            .up_m       (up_m[i]),
            .dn_m       (dn_m[i]),
            .busy       (busy[i]),
            .fault      (fault[i]),
            .fault_code (fault_code[2*i+1:2*i])
`ifdef MOTOR_CTRL_TRAVEL_LOG_EN
            ,
            .travel_cyc (travel_cyc[i*TIMEOUT_W +: TIMEOUT_W])
`endif
        );
    end

endmodule
